// File: rtl/n_register_serializer.sv
// Parallel-to-serial reader: loads a WIDTH-bit word on a valid/ready handshake and
// shifts it out LSB-first. Optional even-parity trailer bit via NREG_SERIAL_PARITY_EN.
module n_register_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_D,
  input  logic             io_load_valid,
  output logic             io_load_ready,
  input  logic             io_pause,
  output logic             io_serial_out,
  output logic             io_serial_valid,
  output logic             io_done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef NREG_SERIAL_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef NREG_SERIAL_PARITY_EN
  logic             parity_q;
`endif

  // Sequencer: load on handshake, shift on unpaused cycles, one-cycle done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef NREG_SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io_load_valid) begin
            shreg_q  <= io_D;
            cnt_q    <= '0;
`ifdef NREG_SERIAL_PARITY_EN
            parity_q <= ^io_D;
`endif
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!io_pause) begin
            shreg_q <= shreg_q >> 1;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
`ifdef NREG_SERIAL_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_DONE;
`endif
            end
          end
        end
`ifdef NREG_SERIAL_PARITY_EN
        S_PARITY: begin
          if (!io_pause) state_q <= S_DONE;
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state; reset and pause gate them to zero.
  always_comb begin
    io_load_ready   = 1'b0;
    io_serial_out   = 1'b0;
    io_serial_valid = 1'b0;
    io_done         = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: io_load_ready = 1'b1;
        S_SHIFT: begin
          io_serial_valid = !io_pause;
          io_serial_out   = !io_pause & shreg_q[0];
        end
`ifdef NREG_SERIAL_PARITY_EN
        S_PARITY: begin
          io_serial_valid = !io_pause;
          io_serial_out   = !io_pause & parity_q;
        end
`endif
        S_DONE:  io_done = 1'b1;
        default: io_load_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_n_register_serializer.sv
// Scoreboard bench for n_register_serializer (WIDTH=8): the driver queues expected
// (cycle, bit) and done events, a negedge monitor pops and compares them.
module tb_n_register_serializer;

  localparam int unsigned WIDTH = 8;
`ifdef NREG_SERIAL_PARITY_EN
  localparam int SPACING = WIDTH + 3;
`else
  localparam int SPACING = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] io_D;
  logic             io_load_valid;
  logic             io_load_ready;
  logic             io_pause;
  logic             io_serial_out;
  logic             io_serial_valid;
  logic             io_done;

  n_register_serializer #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .io_D            (io_D),
    .io_load_valid   (io_load_valid),
    .io_load_ready   (io_load_ready),
    .io_pause        (io_pause),
    .io_serial_out   (io_serial_out),
    .io_serial_valid (io_serial_valid),
    .io_done         (io_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int cyc;
    bit val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_e0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every valid bit or done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!io_serial_valid && io_serial_out)
      chk("serial_out_gated", 64'(io_serial_out), 64'd0);
    if (io_serial_valid || io_done) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {31'd0, io_done, 32'(cyc)}, 64'd0);
      end else begin
        e = q.pop_front();
        chk(io_done ? "done_event" : "serial_bit",
            {30'd0, io_done, io_serial_out, 32'(cyc)},
            {30'd0, e.is_done, e.val, 32'(e.cyc)});
      end
    end
  end

  function automatic bit in_pause(input int c, input int e0, input int ps, input int pl);
    return (pl > 0) && (c >= e0 + ps) && (c < e0 + ps + pl);
  endfunction

  // Offer w, queue its expected bits/done, apply a pause window, and leave io_D=nxt.
  task automatic send(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] nxt,
                      input int ps, input int pl, input bit hold);
    int e0;
    int t;
    int guard;
    int done_cyc;
    io_D          = w;
    io_load_valid = 1'b1;
    guard = 0;
    while (!io_load_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!io_load_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
      io_load_valid = 1'b0;
      return;
    end
    e0 = cyc;
    last_e0 = e0;
    t = e0 + 1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      while (in_pause(t, e0, ps, pl)) t++;
      q.push_back('{is_done: 1'b0, cyc: t, val: w[i]});
      t++;
    end
`ifdef NREG_SERIAL_PARITY_EN
    while (in_pause(t, e0, ps, pl)) t++;
    q.push_back('{is_done: 1'b0, cyc: t, val: ^w});
    t++;
`endif
    q.push_back('{is_done: 1'b1, cyc: t, val: 1'b0});
    done_cyc = t;
    @(posedge clk); #1;
    io_D = nxt;
    if (!hold) io_load_valid = 1'b0;
    while (cyc <= done_cyc) begin
      io_pause = in_pause(cyc, e0, ps, pl);
      @(posedge clk); #1;
    end
    io_pause = 1'b0;
    chk("ready_after_done", 64'(io_load_ready), 64'd1);
  endtask

  initial begin
    int e0;
    int e_first;
    reset         = 1'b1;
    io_D          = '0;
    io_load_valid = 1'b1;
    io_pause      = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_outputs", {60'd0, io_load_ready, io_serial_out, io_serial_valid, io_done}, 64'd0);
    end
    reset         = 1'b0;
    io_load_valid = 1'b0;
    io_pause      = 1'b0;
    #1;
    chk("ready_after_reset", 64'(io_load_ready), 64'd1);

    send(8'hA5, 8'h00, 0, 0, 1'b0);
    send(8'h07, 8'hF0, 0, 0, 1'b0);
    send(8'hFF, 8'h00, 3, 3, 1'b0);

    // Back-to-back with valid held; io_D changes to the next word mid-shift.
    send(8'h3C, 8'hC3, 0, 0, 1'b1);
    e_first = last_e0;
    send(8'hC3, 8'h00, 0, 0, 1'b0);
    chk("b2b_spacing", 64'(last_e0 - e_first), 64'(SPACING));

    // Reset mid-word: three bits out, reset in cycle E0+4, no done pulse.
    io_D          = 8'h5A;
    io_load_valid = 1'b1;
    chk("ready_before_abort", 64'(io_load_ready), 64'd1);
    e0 = cyc;
    for (int i = 0; i < 3; i++) q.push_back('{is_done: 1'b0, cyc: e0 + 1 + i, val: io_D[i]});
    repeat (4) begin
      @(posedge clk); #1;
      io_load_valid = 1'b0;
      io_D          = 8'h00;
    end
    reset = 1'b1;
    #1;
    chk("midword_reset_outputs", {60'd0, io_load_ready, io_serial_out, io_serial_valid, io_done}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("ready_after_abort", 64'(io_load_ready), 64'd1);
    chk("abort_drained", 64'(q.size()), 64'd0);

    send(8'h81, 8'h00, 0, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
